// File: rtl/reliable_recv_action_core.sv
// Receive-side reliable action core: joins each PHV with its match result,
// classifies the PSN against the flow's expected PSN and stamps an ACK code.
module reliable_recv_action_core #(
    parameter int VALUE_WIDTH     = 32,
    parameter int PHV_B_COUNT     = 7,
    parameter int PHV_H_COUNT     = 2,
    parameter int PHV_W_COUNT     = 10,
    parameter int PHV_WIDTH       = PHV_B_COUNT*8 + PHV_H_COUNT*16
                                  + PHV_W_COUNT*32,
    parameter int FLOWSTATE_WIDTH = 32,
    parameter int ADDR_WIDTH      = 10,
    parameter int OPCODE_WIDTH    = 4,
    parameter int PSN_OFFSET      = 0,
    parameter int ACK_OFFSET      = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    reliable_enable,
    input  logic                    s_mat_hit,
    input  logic [ADDR_WIDTH-1:0]   s_mat_addr,
    input  logic                    s_mat_valid,
    output logic                    s_mat_ready,
    input  logic [PHV_WIDTH-1:0]    s_phv_info,
    input  logic                    s_phv_valid,
    output logic                    s_phv_ready,
    input  logic [ADDR_WIDTH-1:0]   s_mod_addr,
    input  logic [VALUE_WIDTH:0]    s_mod_data,
    input  logic [OPCODE_WIDTH-1:0] s_mod_opcode,
    input  logic                    s_mod_valid,
    output logic                    s_mod_ready,
    output logic [VALUE_WIDTH:0]    m_mod_bdata,
    output logic                    m_mod_bvalid,
    input  logic                    m_mod_bready,
    output logic [PHV_WIDTH-1:0]    m_phv_info,
    output logic                    m_phv_valid,
    input  logic                    m_phv_ready
);

    localparam int FW    = FLOWSTATE_WIDTH;
    localparam int DEPTH = 1 << ADDR_WIDTH;

    localparam logic [OPCODE_WIDTH-1:0] OP_WRITE = OPCODE_WIDTH'(1);
    localparam logic [OPCODE_WIDTH-1:0] OP_READ  = OPCODE_WIDTH'(2);
    localparam logic [OPCODE_WIDTH-1:0] OP_CLEAR = OPCODE_WIDTH'(13);

    typedef enum logic [1:0] {
        ST_CLEAR,
        ST_RUN,
        ST_MOD_RSP
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [ADDR_WIDTH-1:0] r_clr_addr;
    logic [FW-1:0]         r_ram [DEPTH];
    logic [FW-1:0]         r_ram_q;

    logic                  r_s1_valid;
    logic                  r_s1_hit;
    logic [ADDR_WIDTH-1:0] r_s1_addr;
    logic [PHV_WIDTH-1:0]  r_s1_phv;
    logic                  r_s1_fwd;
    logic [FW-1:0]         r_s1_fwd_data;

    logic                  r_out_valid;
    logic [PHV_WIDTH-1:0]  r_out_phv;
    logic                  r_bvalid;
    logic [VALUE_WIDTH:0]  r_bdata;

    logic                  w_stall;
    logic                  w_run;
    logic                  w_join;
    logic                  w_mod_ready;
    logic                  w_mod_acc;
    logic                  w_re;
    logic [ADDR_WIDTH-1:0] w_raddr;
    logic                  w_we;
    logic [ADDR_WIDTH-1:0] w_waddr;
    logic [FW-1:0]         w_wdata;
    logic [FW-1:0]         w_expected;
    logic [FW-1:0]         w_psn;
    logic [FW-1:0]         w_diff;
    logic [7:0]            w_code;
    logic                  w_ack_wr;
    logic [PHV_WIDTH-1:0]  w_out_phv;
    logic                  w_unused_ok;

    assign w_unused_ok = s_mod_data[VALUE_WIDTH];

    assign w_stall     = r_out_valid && !m_phv_ready;
    assign w_run       = (r_state == ST_RUN);
    // A waiting control request holds off new joins so the pipe can drain
    assign w_join      = w_run && !w_stall && s_phv_valid && s_mat_valid
                       && !s_mod_valid;
    assign w_mod_ready = w_run && !r_s1_valid && !r_out_valid;
    assign w_mod_acc   = w_mod_ready && s_mod_valid;

    assign s_phv_ready = w_join;
    assign s_mat_ready = w_join;
    assign s_mod_ready = w_mod_ready;

    assign w_re    = w_join || (w_mod_acc && s_mod_opcode == OP_READ);
    assign w_raddr = w_join ? s_mat_addr : s_mod_addr;

    assign w_expected = r_s1_fwd ? r_s1_fwd_data : r_ram_q;
    assign w_psn      = r_s1_phv[PSN_OFFSET +: FW];
    assign w_diff     = w_psn - w_expected;

    always_comb begin
        w_code = 8'h00;
        if (r_s1_hit && reliable_enable) begin
            if (w_diff == '0) begin
                w_code = 8'h01;
            end else if (!w_diff[FW-1]) begin
                w_code = 8'h02;
            end else begin
                w_code = 8'h03;
            end
        end
        w_out_phv = r_s1_phv;
        w_out_phv[ACK_OFFSET +: 8] = w_code;
    end

    assign w_ack_wr = r_s1_valid && !w_stall && (w_code == 8'h01);

    always_comb begin
        w_state_nxt = r_state;
        w_we        = 1'b0;
        w_waddr     = r_s1_addr;
        w_wdata     = w_expected + FW'(1);
        unique case (r_state)
            ST_CLEAR: begin
                w_we    = 1'b1;
                w_waddr = r_clr_addr;
                w_wdata = '0;
                if (&r_clr_addr) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                w_we = w_ack_wr;
                if (w_mod_acc) begin
                    unique case (s_mod_opcode)
                        OP_WRITE: begin
                            w_we    = 1'b1;
                            w_waddr = s_mod_addr;
                            w_wdata = s_mod_data[FW-1:0];
                        end
                        OP_READ:  w_state_nxt = ST_MOD_RSP;
                        OP_CLEAR: w_state_nxt = ST_CLEAR;
                        default:  w_state_nxt = ST_RUN;
                    endcase
                end
            end
            ST_MOD_RSP: begin
                if (r_bvalid && m_mod_bready) begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: w_state_nxt = ST_CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_CLEAR;
            r_clr_addr <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_CLEAR) begin
                r_clr_addr <= r_clr_addr + ADDR_WIDTH'(1);
            end else begin
                r_clr_addr <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_we) begin
            r_ram[w_waddr] <= w_wdata;
        end
        if (w_re) begin
            r_ram_q <= r_ram[w_raddr];
        end
    end

    // Forward a write landing on the same edge as the read, since the
    // RAM returns the old contents in that case
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_phv   <= '0;
        end else if (!w_stall) begin
            r_s1_valid  <= w_join;
            r_out_valid <= r_s1_valid;
            if (w_join) begin
                r_s1_hit      <= s_mat_hit;
                r_s1_addr     <= s_mat_addr;
                r_s1_phv      <= s_phv_info;
                r_s1_fwd      <= w_we && (w_waddr == s_mat_addr);
                r_s1_fwd_data <= w_wdata;
            end
            if (r_s1_valid) begin
                r_out_phv <= w_out_phv;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bvalid <= 1'b0;
            r_bdata  <= '0;
        end else if (r_state == ST_MOD_RSP) begin
            if (!r_bvalid) begin
                r_bvalid <= 1'b1;
                r_bdata  <= {1'b1, r_ram_q};
            end else if (m_mod_bready) begin
                r_bvalid <= 1'b0;
                r_bdata  <= '0;
            end
        end
    end

    assign m_phv_valid  = r_out_valid;
    assign m_phv_info   = r_out_phv;
    assign m_mod_bvalid = r_bvalid;
    assign m_mod_bdata  = r_bdata;

endmodule

// File: tb/tb_reliable_recv_action_core.sv
// Bench for reliable_recv_action_core: directed scenarios plus randomized
// traffic scored against a per-flow expected-PSN model.
module tb_reliable_recv_action_core;

    localparam int PW    = 408;
    localparam int AW    = 10;
    localparam int DEPTH = 1024;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          reliable_enable = 1'b1;
    logic          s_mat_hit = 1'b0;
    logic [AW-1:0] s_mat_addr = '0;
    logic          s_mat_valid = 1'b0;
    logic          s_mat_ready;
    logic [PW-1:0] s_phv_info = '0;
    logic          s_phv_valid = 1'b0;
    logic          s_phv_ready;
    logic [AW-1:0] s_mod_addr = '0;
    logic [32:0]   s_mod_data = '0;
    logic [3:0]    s_mod_opcode = '0;
    logic          s_mod_valid = 1'b0;
    logic          s_mod_ready;
    logic [32:0]   m_mod_bdata;
    logic          m_mod_bvalid;
    logic          m_mod_bready = 1'b1;
    logic [PW-1:0] m_phv_info;
    logic          m_phv_valid;
    logic          m_phv_ready = 1'b1;

    reliable_recv_action_core dut (
        .clk             (clk),
        .rst             (rst),
        .reliable_enable (reliable_enable),
        .s_mat_hit       (s_mat_hit),
        .s_mat_addr      (s_mat_addr),
        .s_mat_valid     (s_mat_valid),
        .s_mat_ready     (s_mat_ready),
        .s_phv_info      (s_phv_info),
        .s_phv_valid     (s_phv_valid),
        .s_phv_ready     (s_phv_ready),
        .s_mod_addr      (s_mod_addr),
        .s_mod_data      (s_mod_data),
        .s_mod_opcode    (s_mod_opcode),
        .s_mod_valid     (s_mod_valid),
        .s_mod_ready     (s_mod_ready),
        .m_mod_bdata     (m_mod_bdata),
        .m_mod_bvalid    (m_mod_bvalid),
        .m_mod_bready    (m_mod_bready),
        .m_phv_info      (m_phv_info),
        .m_phv_valid     (m_phv_valid),
        .m_phv_ready     (m_phv_ready)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [511:0] got,
                       input logic [511:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    logic [31:0] mdl [DEPTH];

    typedef struct {
        logic [PW-1:0] phv;
        int            acc;
        bit            lat;
    } exp_t;
    exp_t q[$];

    bit lat_mode = 0;
    bit bp_mode = 0;
    int hold_n = 0;

    function automatic void model_accept(bit hit, int addr,
                                         logic [PW-1:0] phv, int exp_code);
        logic [31:0] psn;
        logic [31:0] e;
        logic [31:0] d;
        logic [7:0]  code;
        exp_t        x;
        psn = phv[31:0];
        e = mdl[addr];
        d = psn - e;
        if (!hit || !reliable_enable) code = 8'h00;
        else if (psn == e) begin
            code = 8'h01;
            mdl[addr] = e + 1;
        end else if (d < 32'h8000_0000) code = 8'h02;
        else code = 8'h03;
        x.phv = phv;
        x.phv[39:32] = (exp_code >= 0) ? exp_code[7:0] : code;
        x.acc = cyc;
        x.lat = lat_mode;
        q.push_back(x);
    endfunction

    initial begin
        bit prev_stall = 0;
        logic [PW-1:0] pinfo;
        exp_t x;
        forever begin
            @(negedge clk);
            if (hold_n > 0) begin
                m_phv_ready = 1'b0;
                hold_n--;
            end else if (bp_mode) begin
                m_phv_ready = ($urandom_range(0, 2) != 0);
            end else begin
                m_phv_ready = 1'b1;
            end
            if (prev_stall) begin
                chk("hold_valid", m_phv_valid, 1);
                chk("hold_info", m_phv_info, pinfo);
            end
            prev_stall = 0;
            if (rst === 1'b0 && m_phv_valid === 1'b1) begin
                if (m_phv_ready) begin
                    if (q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL unexpected_phv got=%0h",
                                 m_phv_info);
                    end else begin
                        x = q.pop_front();
                        chk("phv", m_phv_info, x.phv);
                        if (x.lat) chk("phv_lat", cyc, x.acc + 2);
                    end
                end else begin
                    prev_stall = 1;
                    pinfo = m_phv_info;
                end
            end
        end
    end

    task automatic send_pkt(input bit hit, input int addr,
                            input logic [31:0] psn, input int exp_code);
        logic [415:0] t;
        logic [PW-1:0] phv;
        bit done = 0;
        for (int i = 0; i < 13; i++) t[i*32 +: 32] = $urandom;
        phv = t[PW-1:0];
        phv[31:0] = psn;
        s_phv_info = phv;
        s_mat_hit = hit;
        s_mat_addr = addr[AW-1:0];
        s_phv_valid = 1'b1;
        s_mat_valid = 1'b1;
        for (int k = 0; k < 300 && !done; k++) begin
            #1;
            if (s_phv_ready) begin
                chk("mat_ready", s_mat_ready, 1);
                model_accept(hit, addr, phv, exp_code);
                done = 1;
            end
            @(negedge clk);
        end
        if (!done) begin
            n_checks++;
            n_errors++;
            $display("FAIL send_timeout got=0 exp=1");
            s_phv_valid = 1'b0;
            s_mat_valid = 1'b0;
        end
    endtask

    task automatic idle();
        s_phv_valid = 1'b0;
        s_mat_valid = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 500 && q.size() > 0; k++) @(negedge clk);
        chk("drain", q.size(), 0);
    endtask

    task automatic mod_issue(input logic [3:0] op, input int addr,
                             input logic [31:0] data,
                             output int acc, output bit ok);
        ok = 0;
        acc = 0;
        s_mod_opcode = op;
        s_mod_addr = addr[AW-1:0];
        s_mod_data = {1'b0, data};
        s_mod_valid = 1'b1;
        for (int k = 0; k < 300 && !ok; k++) begin
            #1;
            if (s_mod_ready) begin
                ok = 1;
                acc = cyc;
            end
            @(negedge clk);
        end
        s_mod_valid = 1'b0;
        if (!ok) begin
            n_checks++;
            n_errors++;
            $display("FAIL mod_timeout got=0 exp=1");
        end
    endtask

    task automatic mod_write(input int addr, input logic [31:0] data);
        int acc;
        bit ok;
        mod_issue(4'h1, addr, data, acc, ok);
        mdl[addr] = data;
    endtask

    task automatic mod_read(input string tag, input int addr,
                            input logic [31:0] exp);
        int acc;
        bit ok;
        bit seen = 0;
        mod_issue(4'h2, addr, 32'h0, acc, ok);
        if (ok) begin
            for (int k = 0; k < 10 && !seen; k++) begin
                if (m_mod_bvalid === 1'b1) begin
                    seen = 1;
                    chk({tag, "_lat"}, cyc, acc + 2);
                    chk(tag, m_mod_bdata, {1'b1, exp});
                end
                @(negedge clk);
            end
            if (!seen) begin
                n_checks++;
                n_errors++;
                $display("FAIL %s_timeout got=0 exp=1", tag);
            end
        end
    endtask

    task automatic clear_window(input string tag);
        int n = 0;
        bit done = 0;
        bit rdy_seen = 0;
        s_mat_hit = 1'b0;
        s_phv_valid = 1'b1;
        s_mat_valid = 1'b1;
        while (!done && n < 3000) begin
            #1;
            if (s_mod_ready) begin
                done = 1;
            end else begin
                if (s_phv_ready || s_mat_ready) rdy_seen = 1;
                n++;
                @(negedge clk);
            end
        end
        s_phv_valid = 1'b0;
        s_mat_valid = 1'b0;
        chk({tag, "_len"}, n, 1024);
        chk({tag, "_rdy"}, rdy_seen, 0);
        for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
        @(negedge clk);
    endtask

    initial begin
        int acc;
        bit ok;
        int a;
        int r;
        logic [31:0] p;

        for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
        s_phv_valid = 1'b1;
        s_mat_valid = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_phv_valid", m_phv_valid, 0);
        chk("rst_phv_info", m_phv_info, 0);
        chk("rst_bvalid", m_mod_bvalid, 0);
        chk("rst_bdata", m_mod_bdata, 0);
        chk("rst_mod_ready", s_mod_ready, 0);
        chk("rst_phv_ready", s_phv_ready, 0);
        chk("rst_mat_ready", s_mat_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        clear_window("reset_clear");
        mod_read("rd_after_reset", 5, 32'h0);

        lat_mode = 1;
        send_pkt(1, 3, 32'd0, 1);
        send_pkt(1, 3, 32'd1, 1);
        send_pkt(1, 3, 32'd2, 1);
        idle();
        drain();
        mod_read("rd_inorder", 3, 32'd3);

        mod_write(7, 32'd10);
        send_pkt(1, 7, 32'd12, 2);
        send_pkt(1, 7, 32'd9, 3);
        send_pkt(1, 7, 32'd10, 1);
        idle();
        drain();
        mod_read("rd_gapdup", 7, 32'd11);

        mod_write(1, 32'hFFFF_FFFF);
        send_pkt(1, 1, 32'hFFFF_FFFF, 1);
        idle();
        drain();
        mod_read("rd_wrap0", 1, 32'h0);
        send_pkt(1, 1, 32'h0, 1);
        idle();
        drain();
        mod_read("rd_wrap1", 1, 32'h1);

        lat_mode = 0;
        hold_n = 8;
        send_pkt(1, 20, 32'd0, 1);
        send_pkt(1, 20, 32'd1, 1);
        idle();
        drain();
        mod_read("rd_bp", 20, 32'd2);

        reliable_enable = 1'b0;
        send_pkt(1, 3, 32'd3, 0);
        idle();
        drain();
        reliable_enable = 1'b1;
        send_pkt(0, 3, 32'd3, 0);
        idle();
        drain();
        mod_read("rd_bypass", 3, 32'd3);
        send_pkt(1, 3, 32'd3, 1);
        idle();
        drain();
        mod_issue(4'h5, 3, 32'd99, acc, ok);
        mod_read("rd_other_op", 3, 32'd4);

        bp_mode = 1;
        for (int n = 0; n < 400; n++) begin
            a = 40 + $urandom_range(0, 3);
            r = $urandom_range(0, 9);
            if (r < 5) p = mdl[a];
            else if (r < 7) p = mdl[a] + $urandom_range(1, 3);
            else if (r < 9) p = mdl[a] - $urandom_range(1, 2);
            else p = $urandom;
            send_pkt($urandom_range(0, 7) != 0, a, p, -1);
            if ($urandom_range(0, 3) == 0) begin
                idle();
                @(negedge clk);
            end
        end
        idle();
        bp_mode = 0;
        drain();
        for (int i = 40; i < 44; i++) begin
            mod_read($sformatf("rd_rand%0d", i), i, mdl[i]);
        end

        mod_issue(4'hD, 0, 32'h0, acc, ok);
        clear_window("run_clear");
        mod_read("rd_clr3", 3, 32'h0);
        mod_read("rd_clr7", 7, 32'h0);
        mod_read("rd_clr40", 40, 32'h0);
        mod_read("rd_clr1023", 1023, 32'h0);

        send_pkt(1, 3, 32'd0, 1);
        idle();
        drain();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
